// File: rtl/ula_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states
// and the op legality check.
package ula_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_SRA = 4'd8,
        OP_MUL = 4'd9
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    function automatic logic op_legal(
        input logic [3:0] op,
        input logic       mul_en
    );
        if (op == OP_MUL) return mul_en;
        return (op < OP_MUL);
    endfunction

endpackage

// File: rtl/ula_mul_seq.sv
// Iterative unsigned shift-add multiplier. The first step is
// folded into the load, so the product is ready WIDTH-1 edges later.
module ula_mul_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iSTART,
    input  logic [WIDTH-1:0]   iA,
    input  logic [WIDTH-1:0]   iB,
    output logic [2*WIDTH-1:0] oP,
    output logic               oDONE
);

    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    logic [W-1:0]  a_q;
    logic [CW-1:0] cnt;
    logic          run;

    // Upper half accumulates A when the current multiplier bit is set,
    // then the whole product register shifts right by one.
    function automatic logic [2*W-1:0] step(
        input logic [2*W-1:0] p,
        input logic [W-1:0]   a
    );
        logic [W:0] s;
        s = {1'b0, p[2*W-1:W]} + {1'b0, {W{p[0]}} & a};
        return {s, p[W-1:1]};
    endfunction

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            a_q   <= '0;
            oP    <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            oDONE <= 1'b0;
        end else begin
            oDONE <= 1'b0;
            if (iSTART) begin
                a_q <= iA;
                oP  <= step({{W{1'b0}}, iB}, iA);
                cnt <= CW'(W - 1);
                run <= 1'b1;
            end else if (run) begin
                oP  <= step(oP, a_q);
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    run   <= 1'b0;
                    oDONE <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ula_seq.sv
// Registered ALU with start/done handshake, accumulator feedback
// and an optional iterative multiplier.
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iSTART,
    input  logic [3:0]       iOP,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iUSE_ACC,
    output logic [WIDTH-1:0] oRESULT,
    output logic [WIDTH-1:0] oRESULT_HI,
    output logic             oOVF,
    output logic             oCARRY,
    output logic             oZERO,
    output logic             oNEG,
    output logic             oBUSY,
    output logic             oDONE
);

    localparam int W = WIDTH;

    state_t         state, state_nx;
    logic [W-1:0]   a_op;
    logic [W-1:0]   r;
    logic [W-1:0]   tmp;
    logic [W:0]     sum;
    logic           ovf, cy;
    logic           legal;
    logic           load_alu, load_mul, mul_go;
    logic [2*W-1:0] mul_p;
    logic           mul_done;
    int             sh;

    assign a_op  = iUSE_ACC ? oRESULT : iA;
    assign legal = op_legal(iOP, MUL_EN);
    assign oBUSY = (state == MUL);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load_alu = 1'b0;
        load_mul = 1'b0;
        mul_go   = 1'b0;
        case (state)
            IDLE: begin
                if (iSTART) begin
                    if (legal && iOP == OP_MUL) begin
                        state_nx = MUL;
                        mul_go   = 1'b1;
                    end else begin
                        load_alu = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    load_mul = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Illegal ops fall through with everything left at zero.
    always_comb begin
        r   = '0;
        tmp = '0;
        sum = '0;
        ovf = 1'b0;
        cy  = 1'b0;
        sh  = int'(iB);
        if (legal) begin
            case (op_t'(iOP))
                OP_ADD: begin
                    sum = {1'b0, a_op} + {1'b0, iB};
                    r   = sum[W-1:0];
                    cy  = sum[W];
                    ovf = (a_op[W-1] == iB[W-1])
                        && (r[W-1] != a_op[W-1]);
                end
                OP_SUB: begin
                    sum = {1'b0, a_op} - {1'b0, iB};
                    r   = sum[W-1:0];
                    cy  = sum[W];
                    ovf = (a_op[W-1] != iB[W-1])
                        && (r[W-1] != a_op[W-1]);
                end
                OP_AND: r = a_op & iB;
                OP_OR:  r = a_op | iB;
                OP_XOR: r = a_op ^ iB;
                OP_NOT: r = ~a_op;
                OP_SHL: begin
                    if (sh >= W) begin
                        r = '0;
                    end else if (sh != 0) begin
                        r   = a_op << sh;
                        tmp = a_op >> (W - sh);
                        cy  = tmp[0];
                    end else begin
                        r = a_op;
                    end
                end
                OP_SHR: begin
                    if (sh >= W) begin
                        r = '0;
                    end else if (sh != 0) begin
                        r   = a_op >> sh;
                        tmp = a_op >> (sh - 1);
                        cy  = tmp[0];
                    end else begin
                        r = a_op;
                    end
                end
                OP_SRA: begin
                    if (sh >= W) begin
                        r = {W{a_op[W-1]}};
                    end else if (sh != 0) begin
                        r   = $signed(a_op) >>> sh;
                        tmp = a_op >> (sh - 1);
                        cy  = tmp[0];
                    end else begin
                        r = a_op;
                    end
                end
                default: r = '0;
            endcase
        end
    end

    generate
        if (MUL_EN) begin : g_mul
            ula_mul_seq #(.WIDTH(W)) u_mul (
                .iCLK   (iCLK),
                .iRST_N (iRST_N),
                .iSTART (mul_go),
                .iA     (a_op),
                .iB     (iB),
                .oP     (mul_p),
                .oDONE  (mul_done)
            );
        end else begin : g_nomul
            assign mul_p    = '0;
            assign mul_done = 1'b0;
        end
    endgenerate

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oRESULT    <= '0;
            oRESULT_HI <= '0;
            oOVF       <= 1'b0;
            oCARRY     <= 1'b0;
            oZERO      <= 1'b0;
            oNEG       <= 1'b0;
            oDONE      <= 1'b0;
        end else begin
            oDONE <= 1'b0;
            if (load_alu) begin
                oRESULT    <= r;
                oRESULT_HI <= '0;
                oOVF       <= ovf;
                oCARRY     <= cy;
                oZERO      <= legal && (r == '0);
                oNEG       <= r[W-1];
                oDONE      <= 1'b1;
            end else if (load_mul) begin
                oRESULT    <= mul_p[W-1:0];
                oRESULT_HI <= mul_p[2*W-1:W];
                oOVF       <= |mul_p[2*W-1:W];
                oCARRY     <= 1'b0;
                oZERO      <= (mul_p == '0);
                oNEG       <= 1'b0;
                oDONE      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: directed vectors push expected
// responses, a negedge monitor pops and compares on oDONE.
module tb_ula_seq;
    import ula_pkg::*;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] res;
        logic         ovf;
        logic         cy;
        logic         z;
        logic         n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         start1 = 1'b0;
    logic         use_acc = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic [W-1:0] res0, hi0, res1, hi1;
    logic ovf0, cy0, z0, n0, busy0, done0;
    logic ovf1, cy1, z1, n1, busy1, done1;

    exp_t  q0[$], q1[$];
    string nq0[$], nq1[$];
    int    checks = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    ula_seq #(.WIDTH(W), .MUL_EN(1'b1)) u0 (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start),
        .iOP(op), .iA(a), .iB(b), .iUSE_ACC(use_acc),
        .oRESULT(res0), .oRESULT_HI(hi0),
        .oOVF(ovf0), .oCARRY(cy0), .oZERO(z0), .oNEG(n0),
        .oBUSY(busy0), .oDONE(done0)
    );

    ula_seq #(.WIDTH(W), .MUL_EN(1'b0)) u1 (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start1),
        .iOP(op), .iA(a), .iB(b), .iUSE_ACC(use_acc),
        .oRESULT(res1), .oRESULT_HI(hi1),
        .oOVF(ovf1), .oCARRY(cy1), .oZERO(z1), .oNEG(n1),
        .oBUSY(busy1), .oDONE(done1)
    );

    function automatic exp_t mk(
        input logic [W-1:0] res, input logic [W-1:0] hi,
        input logic ovf, input logic cy,
        input logic z, input logic n
    );
        exp_t e;
        e = '{hi: hi, res: res, ovf: ovf, cy: cy, z: z, n: n};
        return e;
    endfunction

    task automatic check(
        input string nm,
        input logic [31:0] act,
        input logic [31:0] req
    );
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h",
                     nm, act, req);
        end
    endtask

    task automatic go(
        input int dut, input logic [3:0] o,
        input logic [W-1:0] aa, input logic [W-1:0] bb,
        input logic acc, input exp_t e, input string nm
    );
        op = o;
        a = aa;
        b = bb;
        use_acc = acc;
        if (dut == 0) begin
            start = 1'b1;
            q0.push_back(e);
            nq0.push_back(nm);
        end else begin
            start1 = 1'b1;
            q1.push_back(e);
            nq1.push_back(nm);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        start1 = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e, act;
        string nm;
        if (done0) begin
            act = '{hi: hi0, res: res0, ovf: ovf0,
                    cy: cy0, z: z0, n: n0};
            if (q0.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL u0 spurious done: got %0h, expected none",
                         act);
            end else begin
                e = q0.pop_front();
                nm = nq0.pop_front();
                check(nm, 32'(act), 32'(e));
            end
        end
        if (done1) begin
            act = '{hi: hi1, res: res1, ovf: ovf1,
                    cy: cy1, z: z1, n: n1};
            if (q1.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL u1 spurious done: got %0h, expected none",
                         act);
            end else begin
                e = q1.pop_front();
                nm = nq1.pop_front();
                check(nm, 32'(act), 32'(e));
            end
        end
    end

    initial begin
        int nd;

        #12;
        check("u0 reset state",
              32'({busy0, done0, hi0, res0, ovf0, cy0, z0, n0}), 0);
        check("u1 reset state",
              32'({busy1, done1, hi1, res1, ovf1, cy1, z1, n1}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        go(0, OP_ADD, 4'd7, 4'd1, 0, mk(4'h8, 0, 1, 0, 0, 1), "add 7+1");
        go(0, OP_SUB, 4'd3, 4'd5, 0, mk(4'hE, 0, 0, 1, 0, 1), "sub 3-5");
        go(0, OP_SUB, 4'd5, 4'd5, 0, mk(4'h0, 0, 0, 0, 1, 0), "sub 5-5");
        @(negedge clk);

        go(0, OP_MUL, 4'hF, 4'hF, 0, mk(4'h1, 4'hE, 1, 0, 0, 0),
           "mul 15x15");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("mul busy cycle %0d", i), 32'(busy0), 1);
            if (i == 1) begin
                op = OP_ADD;
                a = 4'd1;
                b = 4'd1;
                start = 1'b1;
            end
            if (i == 2) start = 1'b0;
        end
        @(negedge clk);
        check("mul done timing", 32'({busy0, done0}), 32'(2'b01));

        go(0, OP_ADD, 4'd1, 4'd1, 0, mk(4'd2, 0, 0, 0, 0, 0), "acc 1+1");
        go(0, OP_ADD, 4'd0, 4'd1, 1, mk(4'd3, 0, 0, 0, 0, 0), "acc +1 a");
        go(0, OP_ADD, 4'd0, 4'd1, 1, mk(4'd4, 0, 0, 0, 0, 0), "acc +1 b");
        go(0, OP_ADD, 4'd0, 4'd1, 1, mk(4'd5, 0, 0, 0, 0, 0), "acc +1 c");
        go(0, OP_ADD, 4'd6, 4'd1, 0, mk(4'd7, 0, 0, 0, 0, 0), "add 6+1");
        go(0, OP_ADD, 4'd0, 4'd1, 1, mk(4'd8, 0, 1, 0, 0, 1), "acc 7+1");

        go(0, OP_SHL, 4'b1001, 4'd1, 0, mk(4'b0010, 0, 0, 1, 0, 0),
           "shl 1001 by 1");
        go(0, OP_SHR, 4'b0001, 4'd1, 0, mk(4'b0000, 0, 0, 1, 1, 0),
           "shr 0001 by 1");
        go(0, OP_SHL, 4'b0110, 4'd0, 0, mk(4'b0110, 0, 0, 0, 0, 0),
           "shl by 0");
        go(0, OP_SRA, 4'b1000, 4'd5, 0, mk(4'b1111, 0, 0, 0, 0, 1),
           "sra 1000 by 5");
        @(negedge clk);

        go(0, OP_MUL, 4'd3, 4'd3, 0, mk(4'd9, 0, 0, 0, 0, 0),
           "mul aborted");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset mid-mul outputs",
              32'({busy0, done0, hi0, res0, ovf0, cy0, z0, n0}), 0);
        q0.delete();
        nq0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            nd += int'(done0);
        end
        check("no done after reset", 32'(nd), 0);

        go(0, OP_ADD, 4'd2, 4'd3, 0, mk(4'd5, 0, 0, 0, 0, 0), "add 2+3");
        go(0, 4'd12, 4'd7, 4'd7, 0, mk(0, 0, 0, 0, 0, 0), "illegal 12");
        go(1, OP_ADD, 4'd1, 4'd2, 0, mk(4'd3, 0, 0, 0, 0, 0),
           "u1 add 1+2");
        go(1, OP_MUL, 4'd3, 4'd3, 0, mk(0, 0, 0, 0, 0, 0),
           "u1 mul illegal");
        @(negedge clk);
        check("u1 no busy", 32'(busy1), 0);
        repeat (3) @(negedge clk);
        check("u0 queue drained", 32'(q0.size()), 0);
        check("u1 queue drained", 32'(q1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/ula_seq.md
# ula_seq

Parametrised, sequential successor to the combinational 4-bit ULA. It is a registered ALU with a start/done handshake, an accumulator feedback mode and a full flag set (overflow, carry, zero, negative). It adds an iterative shift-add multiplier with a double-width result. It sits between the SW/KEY input logic and the LEDR/HEX/LCD output logic of the board top level.

## Interface
- WIDTH, 4: operand and result width, ≥2.
- MUL_EN, 1: 1 instantiates the multiplier; 0 makes op MUL illegal.
- iCLK  in  1  system clock (CLOCK_50 at top).
- iRST_N  in  1  reset, asynchronous, active-low.
- iSTART  in  1  request; sampled on rising edge only when idle.
- iOP  in  4  operation code (ula_pkg::op_t).
- iA  in  WIDTH  operand A.
- iB  in  WIDTH  operand B / shift amount.
- iUSE_ACC  in  1  1: operand A = current oRESULT instead of iA.
- oRESULT  out  WIDTH  result (low half for MUL).
- oRESULT_HI  out  WIDTH  MUL high half; 0 after any other op.
- oOVF, oCARRY, oZERO, oNEG  out  1 each  flags of last completed op.
- oBUSY  out  1  multiplier running; iSTART ignored.
- oDONE  out  1  one-cycle pulse: outputs updated this cycle.

## Operation
- Op codes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR (logical), 8 SRA, 9 MUL (unsigned). 10–15 are illegal.
- Operands, op and iUSE_ACC are captured at the accepting edge. Later input changes have no effect on an operation in progress.
- ADD/SUB use two's complement.
  - oOVF is signed overflow.
  - oCARRY is the carry-out for ADD and the borrow (A<B unsigned) for SUB.
- AND, OR, XOR and NOT clear oOVF and oCARRY.
- Shifts:
  - The amount is iB as unsigned.
  - If the amount is ≥ WIDTH, SHL/SHR give 0 and SRA gives sign fill; oCARRY = 0 in that case.
  - Otherwise oCARRY is the last bit shifted out; oCARRY = 0 for an amount of 0.
  - oOVF = 0.
- MUL:
  - Produces a 2·WIDTH product {oRESULT_HI, oRESULT}.
  - oOVF = (oRESULT_HI ≠ 0), oCARRY = 0, oNEG = 0.
  - oZERO tests the full product.
- Other ops: oZERO = (oRESULT == 0) and oNEG = oRESULT[WIDTH-1].
- Illegal op: oRESULT = 0, oRESULT_HI = 0, all flags 0, oDONE still pulses.
- FSM states:
  - IDLE: iSTART with a non-MUL op → compute, register outputs, pulse oDONE, stay IDLE. iSTART with MUL → MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles, then register outputs, pulse oDONE, go to IDLE.
- Reset (any time, including mid-MUL):
  - All outputs go to 0 immediately; FSM goes to IDLE; the multiplier is aborted.
  - No oDONE follows reset release.

## Timing
- Start accepted at edge k, non-MUL op: outputs and oDONE valid after edge k+1. oBUSY stays 0.
- Back-to-back starts every cycle are allowed for non-MUL ops.
- With iUSE_ACC, operand A is the oRESULT value present before the accepting edge, so chaining works at full rate.
- Start accepted at edge k, MUL: oBUSY = 1 after edges k+1..k+WIDTH. Outputs and oDONE are valid after edge k+WIDTH+1, with oBUSY = 0 in that cycle. A new start is accepted at edge k+WIDTH+1.
- iSTART while oBUSY = 1 is dropped, not queued.
- Outputs hold their values between operations.

## Structure
- Package ula_pkg holds:
  - op_t enum (4 bits, codes above);
  - state_t {IDLE, MUL};
  - a function returning whether an op is legal for a given MUL_EN.
- Sub-module ula_mul_seq (WIDTH):
  - iterative unsigned shift-add multiplier;
  - ports: iCLK, iRST_N, iSTART, iA, iB, oP[2·WIDTH-1:0], oDONE.
- The combinational op datapath and flag logic live in ula_seq itself.
- The board top instantiates ula_seq with WIDTH=4, driving iA=SW[3:0], iB=SW[7:4], iOP=SW[11:8].

## Test plan
- WIDTH=4, ADD 7+1, start at edge k → at k+1: oRESULT=8, oOVF=1, oNEG=1, oCARRY=0, oZERO=0, oDONE single pulse.
- SUB 3−5 → oRESULT=4'hE, oCARRY=1, oOVF=0, oNEG=1. Then SUB 5−5 → oRESULT=0, oZERO=1, oCARRY=0.
- MUL 15×15, start at edge k:
  - oBUSY high for 4 cycles;
  - at k+5: oRESULT_HI=4'hE, oRESULT=4'h1, oOVF=1, oDONE pulse;
  - an iSTART issued at k+2 produces no extra oDONE.
- Accumulator chain: ADD 1+1, then three consecutive-cycle starts ADD with iUSE_ACC=1, iB=1 → oRESULT 2, 3, 4, 5 on successive cycles. Final ADD 7+1 via accumulator shows oOVF=1.
- Shifts:
  - SHL 4'b1001 by 1 → 4'b0010, oCARRY=1;
  - SHR 4'b0001 by 1 → 0, oZERO=1, oCARRY=1;
  - SRA 4'b1000 by 5 → 4'b1111, oCARRY=0.
- Reset and illegal op:
  - iRST_N low 2 cycles into MUL → all outputs 0 immediately; no oDONE after release.
  - Then op 12 → oRESULT=0, all flags 0, oDONE pulses.
  - Repeat with MUL_EN=0, op 9 → same illegal response.
